// File: rtl/pipe_chain_pkg.sv
// Shared constants for the pipeline stage chain, plus the saturating add
// used by the flush-drop counter.
package pipe_chain_pkg;

  localparam int ADDRESS_LEN    = 32;
  localparam int PIPE_MAX_DEPTH = 16;
  localparam int PIPE_DROP_W    = 16;
  localparam int PIPE_INC_W     = $clog2(PIPE_MAX_DEPTH + 1);

  // Per-edge drop increments are at most PIPE_MAX_DEPTH; clamp at all-ones.
  function automatic logic [PIPE_DROP_W-1:0] sat_add_drop(
    input logic [PIPE_DROP_W-1:0] acc,
    input logic [PIPE_INC_W-1:0]  inc
  );
    logic [PIPE_DROP_W:0] sum;
    sum = {1'b0, acc} + {{(PIPE_DROP_W + 1 - PIPE_INC_W){1'b0}}, inc};
    return sum[PIPE_DROP_W] ? {PIPE_DROP_W{1'b1}} : sum[PIPE_DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready payload channel used on both ends of the stage chain.
// A beat transfers on any rising edge where valid and ready are both high;
// the master holds valid and data stable until that edge, and ready may
// depend combinationally on the receiver's state but never on valid.
interface pipe_chain_if #(
  parameter int WIDTH = pipe_chain_pkg::ADDRESS_LEN
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_chain_slot.sv
// One stage register of the chain: a valid bit and a payload word that
// loads from its source when the stage can take a new item.
module pipe_chain_slot
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = ADDRESS_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  input  logic             adv_i,
  input  logic             flush_i,
  input  logic             freeze_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_next_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;

  // The stage takes its source whenever its current content leaves or it is empty.
  assign accept       = ~freeze_i & (~valid_q | adv_i);
  assign valid_next_o = accept ? src_valid_i : valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_next_o & ~flush_i;
      if (accept && src_valid_i) begin
        data_q <= src_data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Configurable chain of stage registers with valid/ready flow control,
// global freeze, per-stage flush, occupancy and a saturating drop counter.
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = ADDRESS_LEN,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_chain_if.slave            in_if,
  pipe_chain_if.master           out_if,
  input  logic                   freeze,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [CNT_W-1:0]       occupancy,
  output logic [PIPE_DROP_W-1:0] drop_count
);

  logic [DEPTH-1:0]       v;
  logic [DEPTH-1:0]       v_n;
  logic [DEPTH-1:0]       adv;
  logic [WIDTH-1:0]       data_s [DEPTH];
  logic [PIPE_INC_W-1:0]  drop_inc;
  logic [CNT_W-1:0]       occ;
  logic [PIPE_DROP_W-1:0] drop_q;
  logic [PIPE_DROP_W-1:0] drop_d;

  // Ready ripples from the output back toward stage 0.
  always_comb begin
    logic a;
    a = out_if.ready & ~freeze;
    adv[DEPTH-1] = a;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      a = ~freeze & (~v[i+1] | a);
      adv[i] = a;
    end
  end

  assign in_if.ready = ~rst & ~freeze & (~v[0] | adv[0]);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (g == 0) begin : g_head
      assign src_valid = in_if.valid;
      assign src_data  = in_if.data;
    end else begin : g_body
      assign src_valid = v[g-1];
      assign src_data  = data_s[g-1];
    end

    pipe_chain_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .adv_i       (adv[g]),
      .flush_i     (flush[g]),
      .freeze_i    (freeze),
      .valid_o     (v[g]),
      .data_o      (data_s[g]),
      .valid_next_o(v_n[g])
    );
  end

  always_comb begin
    occ      = '0;
    drop_inc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ      = occ + CNT_W'(v[i]);
      drop_inc = drop_inc + PIPE_INC_W'(v_n[i] & flush[i]);
    end
  end

  assign drop_d = sat_add_drop(drop_q, drop_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign out_if.valid = v[DEPTH-1];
  assign out_if.data  = data_s[DEPTH-1];
  assign stage_valid  = v;
  assign occupancy    = occ;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (DEPTH=4, WIDTH=32): table of per-cycle
// vectors plus hand sequences for drop-counter saturation and reset.
module tb_pipe_chain;
  import pipe_chain_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             freeze;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] occupancy;
  logic [15:0]      drop_count;

  pipe_chain_if #(.WIDTH(WIDTH)) in_if ();
  pipe_chain_if #(.WIDTH(WIDTH)) out_if ();

  pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (in_if),
    .out_if     (out_if),
    .freeze     (freeze),
    .flush      (flush),
    .stage_valid(stage_valid),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        frz;
    logic [3:0]  fl;
    logic        ordy;
    logic [3:0]  sv;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic [2:0]  occ;
    logic [15:0] drop;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic iv, input logic [31:0] d, input logic frz, input logic [3:0] fl,
                     input logic ordy, input logic [3:0] sv, input logic ov, input logic [31:0] od,
                     input logic ir, input logic [2:0] occ, input logic [15:0] drop);
    vec_t v;
    v.iv = iv; v.d = d; v.frz = frz; v.fl = fl; v.ordy = ordy;
    v.sv = sv; v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.drop = drop;
    vecs.push_back(v);
  endtask

  // driver: inputs set just after an edge, outputs sampled 1ns later
  task automatic drive(input logic iv, input logic [31:0] d, input logic frz,
                       input logic [3:0] fl, input logic ordy);
    in_if.valid  = iv;
    in_if.data   = d;
    freeze       = frz;
    flush        = fl;
    out_if.ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    tick();
    check("reset in_ready c0", {31'b0, in_if.ready}, 32'd0);
    tick();
    check("reset in_ready c1", {31'b0, in_if.ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset stage_valid", {28'b0, stage_valid}, 32'h0);
    check("reset out_valid", {31'b0, out_if.valid}, 32'd0);
    check("reset occupancy", {29'b0, occupancy}, 32'd0);
    check("reset drop_count", {16'b0, drop_count}, 32'd0);
    check("post-reset in_ready", {31'b0, in_if.ready}, 32'd1);

    // streaming 0x10..0x17 with out_ready=1: head appears 4 cycles after accept
    //   iv  data   frz fl    or    sv     ov  od     ir  occ drop
    add(1, 32'h10, 0, 4'h0, 1, 4'b0000, 0, 32'h0,  1, 0, 0);
    add(1, 32'h11, 0, 4'h0, 1, 4'b0001, 0, 32'h0,  1, 1, 0);
    add(1, 32'h12, 0, 4'h0, 1, 4'b0011, 0, 32'h0,  1, 2, 0);
    add(1, 32'h13, 0, 4'h0, 1, 4'b0111, 0, 32'h0,  1, 3, 0);
    add(1, 32'h14, 0, 4'h0, 1, 4'b1111, 1, 32'h10, 1, 4, 0);
    add(1, 32'h15, 0, 4'h0, 1, 4'b1111, 1, 32'h11, 1, 4, 0);
    add(1, 32'h16, 0, 4'h0, 1, 4'b1111, 1, 32'h12, 1, 4, 0);
    add(1, 32'h17, 0, 4'h0, 1, 4'b1111, 1, 32'h13, 1, 4, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1111, 1, 32'h14, 1, 4, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1110, 1, 32'h15, 1, 3, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1100, 1, 32'h16, 1, 2, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1000, 1, 32'h17, 1, 1, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b0000, 0, 32'h0,  1, 0, 0);
    // backpressure: only four of six offers accepted, then ordered drain
    add(1, 32'h20, 0, 4'h0, 0, 4'b0000, 0, 32'h0,  1, 0, 0);
    add(1, 32'h21, 0, 4'h0, 0, 4'b0001, 0, 32'h0,  1, 1, 0);
    add(1, 32'h22, 0, 4'h0, 0, 4'b0011, 0, 32'h0,  1, 2, 0);
    add(1, 32'h23, 0, 4'h0, 0, 4'b0111, 0, 32'h0,  1, 3, 0);
    add(1, 32'h24, 0, 4'h0, 0, 4'b1111, 1, 32'h20, 0, 4, 0);
    add(1, 32'h24, 0, 4'h0, 0, 4'b1111, 1, 32'h20, 0, 4, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1111, 1, 32'h20, 1, 4, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1110, 1, 32'h21, 1, 3, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1100, 1, 32'h22, 1, 2, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1000, 1, 32'h23, 1, 1, 0);
    add(0, 32'h0,  0, 4'h0, 1, 4'b0000, 0, 32'h0,  1, 0, 0);
    // fill, freeze three cycles, resume with the same next item
    add(1, 32'h30, 0, 4'h0, 0, 4'b0000, 0, 32'h0,  1, 0, 0);
    add(1, 32'h31, 0, 4'h0, 0, 4'b0001, 0, 32'h0,  1, 1, 0);
    add(1, 32'h32, 0, 4'h0, 0, 4'b0011, 0, 32'h0,  1, 2, 0);
    add(1, 32'h33, 0, 4'h0, 0, 4'b0111, 0, 32'h0,  1, 3, 0);
    add(1, 32'h34, 1, 4'h0, 1, 4'b1111, 1, 32'h30, 0, 4, 0);
    add(1, 32'h34, 1, 4'h0, 1, 4'b1111, 1, 32'h30, 0, 4, 0);
    add(1, 32'h34, 1, 4'h0, 1, 4'b1111, 1, 32'h30, 0, 4, 0);
    add(1, 32'h34, 0, 4'h0, 1, 4'b1111, 1, 32'h30, 1, 4, 0);
    add(1, 32'h35, 0, 4'h0, 1, 4'b1111, 1, 32'h31, 1, 4, 0);
    // branch flush of the two youngest while the oldest is emitted
    add(1, 32'h36, 0, 4'h3, 1, 4'b1111, 1, 32'h32, 1, 4, 0);
    add(0, 32'h0,  0, 4'h0, 0, 4'b1100, 1, 32'h33, 1, 2, 2);
    // bubble collapse toward the stalled head
    add(1, 32'h37, 0, 4'h0, 0, 4'b1100, 1, 32'h33, 1, 2, 2);
    add(0, 32'h0,  0, 4'h0, 0, 4'b1101, 1, 32'h33, 1, 3, 2);
    add(0, 32'h0,  0, 4'h0, 0, 4'b1110, 1, 32'h33, 1, 3, 2);
    add(1, 32'h38, 0, 4'h0, 0, 4'b1110, 1, 32'h33, 1, 3, 2);
    // flush overrides freeze on a full pipe
    add(1, 32'h39, 1, 4'hF, 1, 4'b1111, 1, 32'h33, 0, 4, 2);
    add(0, 32'h0,  0, 4'h0, 0, 4'b0000, 0, 32'h0,  1, 0, 6);
    // flush of the last stage alongside an output transfer
    add(1, 32'h40, 0, 4'h0, 0, 4'b0000, 0, 32'h0,  1, 0, 6);
    add(1, 32'h41, 0, 4'h0, 0, 4'b0001, 0, 32'h0,  1, 1, 6);
    add(1, 32'h42, 0, 4'h0, 0, 4'b0011, 0, 32'h0,  1, 2, 6);
    add(1, 32'h43, 0, 4'h0, 0, 4'b0111, 0, 32'h0,  1, 3, 6);
    add(0, 32'h0,  0, 4'h8, 1, 4'b1111, 1, 32'h40, 1, 4, 6);
    add(0, 32'h0,  0, 4'h0, 1, 4'b0110, 0, 32'h0,  1, 2, 7);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1100, 1, 32'h42, 1, 2, 7);
    add(0, 32'h0,  0, 4'h0, 1, 4'b1000, 1, 32'h43, 1, 1, 7);
    add(0, 32'h0,  0, 4'h0, 1, 4'b0000, 0, 32'h0,  1, 0, 7);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].frz, vecs[i].fl, vecs[i].ordy);
      #1;
      check($sformatf("v%0d stage_valid", i), {28'b0, stage_valid}, {28'b0, vecs[i].sv});
      check($sformatf("v%0d out_valid", i), {31'b0, out_if.valid}, {31'b0, vecs[i].ov});
      if (vecs[i].ov) check($sformatf("v%0d out_data", i), out_if.data, vecs[i].od);
      check($sformatf("v%0d in_ready", i), {31'b0, in_if.ready}, {31'b0, vecs[i].ir});
      check($sformatf("v%0d occupancy", i), {29'b0, occupancy}, {29'b0, vecs[i].occ});
      check($sformatf("v%0d drop_count", i), {16'b0, drop_count}, {16'b0, vecs[i].drop});
      tick();
    end

    // one drop per cycle: flush stage 0 while feeding it
    for (int i = 0; i < 16'hFFFE - 7; i++) begin
      drive(1'b1, 32'h50, 1'b0, 4'h1, 1'b1);
      tick();
    end
    check("drop preload 0xFFFE", {16'b0, drop_count}, 32'hFFFE);
    check("drop preload stage_valid", {28'b0, stage_valid}, 32'h0);
    tick();
    check("drop saturates", {16'b0, drop_count}, 32'hFFFF);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h60 + 32'(i), 1'b0, 4'h0, 1'b0);
      tick();
    end
    check("refill stage_valid", {28'b0, stage_valid}, 32'hF);
    drive(1'b0, 32'h0, 1'b1, 4'hF, 1'b1);
    tick();
    check("sat flush stage_valid", {28'b0, stage_valid}, 32'h0);
    check("drop stays saturated", {16'b0, drop_count}, 32'hFFFF);

    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("re-reset drop_count", {16'b0, drop_count}, 32'h0);
    check("re-reset occupancy", {29'b0, occupancy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
